// File: rtl/soma_array.sv
// soma_array: NUM_CH integrate-and-fire neuron channels with refractory period and axon delay.
// Define SOMA_ARRAY_LEAK_EN to enable the per-tick shift leak (V -= V >> leak_shift).
module soma_array #(
    parameter int NUM_CH = 4,
    parameter int V_W    = 16,
    parameter int W_W    = 16,
    localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              kill,
    input  logic              cfg_we,
    input  logic [CW-1:0]     cfg_ch,
    input  logic [31:0]       cfg_data,
    input  logic              tick,
    input  logic              in_valid,
    input  logic [CW-1:0]     in_ch,
    input  logic [W_W-1:0]    in_weight,
    output logic              in_ready,
    output logic [NUM_CH-1:0] spike_vec,
    output logic [NUM_CH-1:0] overrun
);
    logic [7:0]     r_vth   [NUM_CH];
    logic [7:0]     r_shift [NUM_CH];
    logic [7:0]     r_rtime [NUM_CH];
    logic [7:0]     r_delay [NUM_CH];
    logic [V_W-1:0] r_v     [NUM_CH];
    logic [7:0]     r_refr  [NUM_CH];
    logic [7:0]     r_dly   [NUM_CH];
    logic           r_pend  [NUM_CH];
    logic           r_spike [NUM_CH];
    logic           r_ovr   [NUM_CH];
    logic           w_acc;

    assign in_ready = en & ~kill & ~cfg_we;
    assign w_acc    = in_valid & in_ready;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [V_W-1:0] w_vl, w_vn;
        logic [V_W:0]   w_sum;
        logic           w_hit, w_fire, w_emit, w_cfg, w_unused_shift;
`ifdef SOMA_ARRAY_LEAK_EN
        assign w_vl = tick ? r_v[c] - (r_v[c] >> r_shift[c]) : r_v[c];
`else
        assign w_vl = r_v[c];
`endif
        assign w_unused_shift = ^r_shift[c];
        assign w_sum  = {1'b0, w_vl} + {{(V_W + 1 - W_W){1'b0}}, in_weight};
        assign w_hit  = w_acc && in_ch == CW'(c) && r_refr[c] == 8'd0;
        assign w_vn   = !w_hit ? w_vl : w_sum[V_W] ? {V_W{1'b1}} : w_sum[V_W-1:0];
        assign w_fire = r_refr[c] == 8'd0 && 32'(w_vn) >= 32'(r_vth[c]);
        assign w_emit = r_pend[c] && r_dly[c] == 8'd0;
        assign w_cfg  = cfg_we && cfg_ch == CW'(c);
        assign spike_vec[c] = r_spike[c];
        assign overrun[c]   = r_ovr[c];

        // A due spike is still emitted on a refire edge; only a spike still in flight is lost.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vth[c]   <= '0;
                r_shift[c] <= '0;
                r_rtime[c] <= '0;
                r_delay[c] <= '0;
                r_v[c]     <= '0;
                r_refr[c]  <= '0;
                r_dly[c]   <= '0;
                r_pend[c]  <= 1'b0;
                r_spike[c] <= 1'b0;
                r_ovr[c]   <= 1'b0;
            end else if (!en) begin
                r_spike[c] <= 1'b0;
            end else if (kill) begin
                r_v[c]     <= '0;
                r_refr[c]  <= '0;
                r_dly[c]   <= '0;
                r_pend[c]  <= 1'b0;
                r_spike[c] <= 1'b0;
                r_ovr[c]   <= 1'b0;
            end else if (w_cfg) begin
                r_vth[c]   <= cfg_data[31:24];
                r_shift[c] <= cfg_data[23:16];
                r_rtime[c] <= cfg_data[15:8];
                r_delay[c] <= cfg_data[7:0];
                r_v[c]     <= '0;
                r_refr[c]  <= '0;
                r_dly[c]   <= '0;
                r_pend[c]  <= 1'b0;
                r_spike[c] <= 1'b0;
            end else begin
                r_spike[c] <= w_emit;
                r_v[c]     <= w_fire ? '0 : w_vn;
                r_refr[c]  <= w_fire ? r_rtime[c] : (tick && r_refr[c] != 8'd0) ? r_refr[c] - 8'd1 : r_refr[c];
                r_dly[c]   <= w_fire ? r_delay[c] : (r_pend[c] && tick && r_dly[c] != 8'd0) ? r_dly[c] - 8'd1 : r_dly[c];
                r_pend[c]  <= w_fire | (r_pend[c] & ~w_emit);
                if (w_fire && r_pend[c] && !w_emit)
                    r_ovr[c] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_soma_array.sv
// tb_soma_array: directed scenarios plus randomized traffic checked every cycle against a behavioural model.
module tb_soma_array;
    localparam int N = 4;
    localparam logic [7:0] NOSH = 8'h20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, kill = 1'b0, cfg_we = 1'b0, tick = 1'b0, in_valid = 1'b0;
    logic [1:0]  cfg_ch = '0, in_ch = '0;
    logic [31:0] cfg_data = '0;
    logic [15:0] in_weight = '0;
    logic        in_ready;
    logic [N-1:0] spike_vec, overrun;

    soma_array dut (
        .clk(clk), .rst_n(rst_n), .en(en), .kill(kill), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_data(cfg_data), .tick(tick), .in_valid(in_valid),
        .in_ch(in_ch), .in_weight(in_weight), .in_ready(in_ready),
        .spike_vec(spike_vec), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v, rf, dl, th, sh, rt, de;
        bit pd, sp, ov;
    } ch_t;

    ch_t m [N];
    ch_t n [N];
    int  checks = 0, errors = 0;
    int  sc [N];
    bit  run = 0;

    task automatic chk(string nm, int idx, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s[%0d] got %0d expected %0d at %0t", nm, idx, act, exp, $time);
        end
    endtask

    // Next state of every channel for the inputs currently driven, from the neuron rules.
    task automatic model_next();
        bit acc;
        acc = in_valid && en && !kill && !cfg_we;
        n = m;
        for (int i = 0; i < N; i++) begin
            ch_t c;
            int vl, vn;
            bit fire, emit;
            c = m[i];
            if (!rst_n) n[i] = '{default: 0};
            else if (!en) n[i].sp = 0;
            else if (kill) begin
                n[i].v = 0; n[i].rf = 0; n[i].dl = 0; n[i].pd = 0; n[i].sp = 0; n[i].ov = 0;
            end else if (cfg_we && int'(cfg_ch) == i) begin
                n[i].th = cfg_data[31:24]; n[i].sh = cfg_data[23:16];
                n[i].rt = cfg_data[15:8];  n[i].de = cfg_data[7:0];
                n[i].v = 0; n[i].rf = 0; n[i].dl = 0; n[i].pd = 0; n[i].sp = 0;
            end else begin
                vl = c.v;
`ifdef SOMA_ARRAY_LEAK_EN
                if (tick) vl = c.v - (c.v >> c.sh);
`endif
                vn = vl;
                if (acc && int'(in_ch) == i && c.rf == 0) vn = (vl + int'(in_weight) > 65535) ? 65535 : vl + int'(in_weight);
                fire = c.rf == 0 && vn >= c.th;
                emit = c.pd && c.dl == 0;
                n[i].sp = emit;
                if (fire) begin
                    if (c.pd && !emit) n[i].ov = 1;
                    n[i].v = 0; n[i].rf = c.rt; n[i].dl = c.de; n[i].pd = 1;
                end else begin
                    n[i].v = vn;
                    if (tick && c.rf > 0) n[i].rf = c.rf - 1;
                    if (emit) n[i].pd = 0;
                    else if (c.pd && tick && c.dl > 0) n[i].dl = c.dl - 1;
                end
            end
        end
    endtask

    always @(negedge clk) if (run) begin
        chk("in_ready", 0, int'(in_ready), int'(en & ~kill & ~cfg_we));
        for (int i = 0; i < N; i++) begin
            chk("spike", i, int'(spike_vec[i]), int'(m[i].sp));
            chk("overrun", i, int'(overrun[i]), int'(m[i].ov));
            chk("v", i, int'(dut.r_v[i]), m[i].v);
            chk("refr", i, int'(dut.r_refr[i]), m[i].rf);
            if (spike_vec[i]) sc[i]++;
        end
    end

    task automatic drive(bit e, bit k, bit cw, int cc, logic [31:0] cd, bit t, bit iv, int ic, int w);
        @(posedge clk); #1;
        m = n;
        en = e; kill = k; cfg_we = cw; cfg_ch = 2'(cc); cfg_data = cd;
        tick = t; in_valid = iv; in_ch = 2'(ic); in_weight = 16'(w);
        model_next();
    endtask

    task automatic idle();                  drive(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic off();                   drive(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic tk();                    drive(1, 0, 0, 0, 0, 1, 0, 0, 0); endtask
    task automatic kl();                    drive(1, 1, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic ev(int ch, int w);       drive(1, 0, 0, 0, 0, 0, 1, ch, w); endtask
    task automatic cfg(int ch, logic [31:0] d); drive(1, 0, 1, ch, d, 0, 0, 0, 0); endtask

    function automatic logic [31:0] mk(int th, logic [7:0] sh, int rt, int de);
        return {8'(th), sh, 8'(rt), 8'(de)};
    endfunction

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 0;
        en = 0; kill = 0; cfg_we = 0; tick = 0; in_valid = 0;
        foreach (m[i]) begin m[i] = '{default: 0}; n[i] = '{default: 0}; end
        @(negedge clk);
        chk("rst_spike", -1, int'(spike_vec), 0);
        chk("rst_overrun", -1, int'(overrun), 0);
        chk("rst_pend1", -1, int'(dut.r_pend[1]), 0);
        @(posedge clk); #1;
        rst_n = 1;
        model_next();
    endtask

    initial begin
        foreach (m[i]) begin m[i] = '{default: 0}; n[i] = '{default: 0}; sc[i] = 0; end
        repeat (2) @(posedge clk);
        run = 1;
        do_reset();
        cfg(0, mk(100, NOSH, 0, 0));
        cfg(1, mk(200, NOSH, 0, 3));
        cfg(2, mk(200, NOSH, 2, 0));
        cfg(3, mk(10, NOSH, 0, 5));
        // Two events cross threshold on the second one
        ev(0, 60); idle(); @(negedge clk); chk("lit_v0_60", -1, int'(dut.r_v[0]), 60);
        ev(0, 50); idle(); @(negedge clk);
        chk("lit_v0_fire", -1, int'(dut.r_v[0]), 0);
        chk("lit_spk0_early", -1, int'(spike_vec[0]), 0);
        idle(); @(negedge clk); chk("lit_spk0", -1, int'(spike_vec[0]), 1);
        idle(); @(negedge clk); chk("lit_spk0_once", -1, int'(spike_vec[0]), 0);
        // Axon delay of three ticks
        ev(1, 200); idle(); @(negedge clk); chk("lit_v1_fire", -1, int'(dut.r_v[1]), 0);
        tk(); tk(); tk(); idle(); @(negedge clk); chk("lit_spk1_early", -1, int'(spike_vec[1]), 0);
        idle(); @(negedge clk); chk("lit_spk1", -1, int'(spike_vec[1]), 1);
        // Refractory discards events until two ticks pass
        ev(2, 200); idle(); @(negedge clk); chk("lit_refr2", -1, int'(dut.r_refr[2]), 2);
        ev(2, 250); idle(); @(negedge clk); chk("lit_v2_ignored", -1, int'(dut.r_v[2]), 0);
        tk(); tk(); ev(2, 250); idle(); @(negedge clk); chk("lit_refr2_again", -1, int'(dut.r_refr[2]), 2);
        idle(); @(negedge clk); chk("lit_spk2", -1, int'(spike_vec[2]), 1);
        // Refire while a spike is in flight
        sc[3] = 0;
        ev(3, 10); tk(); tk(); ev(3, 10); idle(); @(negedge clk); chk("lit_ovr3", -1, int'(overrun[3]), 1);
        tk(); tk(); tk(); tk(); tk(); idle(); idle(); @(negedge clk); chk("lit_spk3", -1, int'(spike_vec[3]), 1);
        idle(); idle(); @(negedge clk); chk("lit_spk3_count", -1, sc[3], 1);
`ifdef SOMA_ARRAY_LEAK_EN
        cfg(0, mk(255, 8'd1, 0, 0));
        ev(0, 64); idle(); @(negedge clk); chk("lit_leak_v64", -1, int'(dut.r_v[0]), 64);
        tk(); tk(); tk(); idle(); @(negedge clk); chk("lit_leak_v8", -1, int'(dut.r_v[0]), 8);
`endif
        cfg(0, mk(255, NOSH, 0, 0));
        ev(0, 100); ev(0, 16'hFFFF); @(negedge clk); chk("lit_sat", -1, int'(dut.g_ch[0].w_vn), 65535);
        idle(); @(negedge clk); chk("lit_sat_fire", -1, int'(dut.r_v[0]), 0);
        // Kill mid-delay
        sc[1] = 0;
        ev(0, 50); ev(1, 200); tk(); kl(); idle(); @(negedge clk);
        chk("lit_kill_ovr", -1, int'(overrun), 0);
        chk("lit_kill_v0", -1, int'(dut.r_v[0]), 0);
        chk("lit_kill_pend1", -1, int'(dut.r_pend[1]), 0);
        tk(); tk(); tk(); tk(); tk(); idle(); idle(); @(negedge clk); chk("lit_kill_nospk", -1, sc[1], 0);
        // Reset mid-delay, then zero config fires continuously
        ev(1, 200); tk(); sc[1] = 0;
        do_reset();
        off(); off(); off(); @(negedge clk); chk("lit_rst_nospk", -1, sc[1], 0);
        idle(); idle(); idle(); @(negedge clk); chk("lit_zero_cfg_spk", -1, int'(spike_vec[0]), 1);
        for (int i = 0; i < N; i++)
            cfg(i, mk($urandom_range(20, 120), 8'($urandom_range(1, 4)), $urandom_range(0, 3), $urandom_range(0, 4)));
        for (int k = 0; k < 3000; k++) begin
            int w;
            w = ($urandom % 8 == 0) ? $urandom_range(1000, 65535) : $urandom_range(0, 60);
            drive(($urandom % 16) != 0, ($urandom % 200) == 0, ($urandom % 100) == 0, $urandom_range(0, 3),
                  mk($urandom_range(0, 150), 8'($urandom_range(0, 5)), $urandom_range(0, 4), $urandom_range(0, 6)),
                  ($urandom % 4) == 0, $urandom % 2, $urandom_range(0, 3), w);
        end
        idle(); idle(); @(negedge clk);
        run = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
